// File: rtl/load_unit.sv
// load_unit: RV32I load execute/memory stage. Computes the effective address, reads
// data memory over a req/gnt/rvalid handshake and returns extended data or a fault.
`default_nettype none

module load_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [11:0]     imm,
  input  logic [4:0]      rd,
  input  logic [2:0]      load_control,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault,
  output logic [1:0]      wb_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] TO_LIM     = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  C_NONE     = 2'b00;
  localparam logic [1:0]  C_MISALIGN = 2'b01;
  localparam logic [1:0]  C_ILLEGAL  = 2'b10;
  localparam logic [1:0]  C_TIMEOUT  = 2'b11;

  state_t          state_q, state_d;
  logic [XLEN-1:0] ea_q, ea_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_fault_q, wb_fault_d;
  logic [1:0]      wb_cause_q, wb_cause_d;

  logic [XLEN-1:0] ea_in;
  logic            illegal_in, misalign_in;
  logic [15:0]     cnt_inc;
  logic            timeout_hit;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ext_data;

  assign ea_in       = rs1_val + {{(XLEN-12){imm[11]}}, imm};
  assign illegal_in  = load_control inside {3'b011, 3'b110, 3'b111};
  assign misalign_in = ((load_control == 3'b001 || load_control == 3'b101) && ea_in[0]) ||
                       ((load_control == 3'b010) && (ea_in[1:0] != 2'b00));
  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

  // Lane extraction uses the latched address, so it is valid only in WAIT.
  always_comb begin
    case (ea_q[1:0])
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  ext_data = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  ext_data = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  ext_data = {{(XLEN-16){1'b0}}, half_v};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ea_d       = ea_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    cnt_d      = cnt_q;
    wb_data_d  = wb_data_q;
    wb_fault_d = wb_fault_q;
    wb_cause_d = wb_cause_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ea_d       = ea_in;
          rd_d       = rd;
          funct3_d   = load_control;
          cnt_d      = 16'd0;
          wb_data_d  = '0;
          wb_fault_d = 1'b0;
          wb_cause_d = C_NONE;
          if (illegal_in) begin
            state_d    = S_DONE;
            wb_fault_d = 1'b1;
            wb_cause_d = C_ILLEGAL;
          end else if (misalign_in) begin
            state_d    = S_DONE;
            wb_fault_d = 1'b1;
            wb_cause_d = C_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d    = S_DONE;
          wb_fault_d = 1'b1;
          wb_cause_d = C_TIMEOUT;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // Data arriving in the expiry cycle takes priority over the timeout.
        if (mem_rvalid) begin
          state_d   = S_DONE;
          wb_data_d = (rd_q == 5'd0) ? '0 : ext_data;
        end else if (timeout_hit) begin
          state_d    = S_DONE;
          wb_fault_d = 1'b1;
          wb_cause_d = C_TIMEOUT;
        end
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ea_q       <= '0;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      cnt_q      <= 16'd0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
      wb_cause_q <= C_NONE;
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      cnt_q      <= cnt_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
      wb_cause_q <= wb_cause_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = {ea_q[XLEN-1:2], 2'b00};
  assign wb_valid = (state_q == S_DONE);
  assign wb_rd    = rd_q;
  assign wb_data  = wb_data_q;
  assign wb_fault = wb_fault_q;
  assign wb_cause = wb_cause_q;

endmodule

`default_nettype wire
